// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the execute-stage request/response handshake and the data memory
//   port of the load/store unit.
//   req_*       : request from execute (valid/ready handshake)
//   resp_*      : one-cycle completion pulse, misaligned flag, load result
//   mem_*       : word-indexed data memory port (read data one cycle late)
//   slave modport  : the load/store unit's view
//   master modport : the requester / memory side view
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic        misaligned;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_data, misaligned,
    output mem_address, mem_write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_data, misaligned,
    input  mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Executes one byte/halfword/word load or store at a time against a
//   word-addressed data memory. Sub-word stores are done read-modify-write.
//   clk   : single clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (request, response and memory port)
//   ALIGN_CHECK : 1 = reject misaligned requests, 0 = force them aligned
//
//   state   | meaning
//   IDLE    | ready for a request; misaligned rejects answered from here
//   RD      | load: memory read strobe
//   LD_DONE | load: extract lane from read data, respond
//   WR      | word store: memory write strobe, respond
//   RMW_RD  | sub-word store: read the containing word
//   RMW_WR  | sub-word store: write merged word, respond
module load_store_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, LD_DONE, WR, RMW_RD, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        misaligned_q, misaligned_d;

  logic        req_bad;
  logic [31:0] req_addr_eff;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Reserved size is always rejected; other misalignments are either rejected
  // or silently aligned depending on ALIGN_CHECK.
  always_comb begin
    req_bad      = 1'b0;
    req_addr_eff = bus.req_addr;
    case (bus.req_size)
      2'b01: if (bus.req_addr[0]) begin
        if (ALIGN_CHECK) req_bad = 1'b1;
        else             req_addr_eff[0] = 1'b0;
      end
      2'b10: if (|bus.req_addr[1:0]) begin
        if (ALIGN_CHECK) req_bad = 1'b1;
        else             req_addr_eff[1:0] = 2'b00;
      end
      2'b11:   req_bad = 1'b1;
      default: ;
    endcase
  end

  // Little-endian lane extraction and store merge against the read word.
  always_comb begin
    byte_v   = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    half_v   = bus.mem_read_data[{addr_q[1], 4'b0000} +: 16];
    load_val = bus.mem_read_data;
    merged   = bus.mem_read_data;
    case (size_q)
      2'b00: begin
        load_val = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = signed_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    misaligned_d = 1'b0;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d   = req_addr_eff;
        size_d   = bus.req_size;
        signed_d = bus.req_signed;
        write_d  = bus.req_write;
        wdata_d  = bus.req_wdata;
        if (req_bad) begin
          resp_valid_d = 1'b1;
          misaligned_d = 1'b1;
          resp_data_d  = 32'h0;
        end else if (!bus.req_write)     state_d = RD;
        else if (bus.req_size == 2'b10)  state_d = WR;
        else                             state_d = RMW_RD;
      end
      RD:      state_d = LD_DONE;
      LD_DONE: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_data_d  = load_val;
      end
      WR, RMW_WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_data_d  = 32'h0;
      end
      RMW_RD:  state_d = RMW_WR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.misaligned     = misaligned_q;
  assign bus.mem_address    = {2'b00, addr_q[31:2]};
  assign bus.mem_read       = (state_q == RD) || (state_q == RMW_RD);
  // write_q is always 1 in the write states; gating keeps the strobe tied to a store.
  assign bus.mem_write      = write_q && ((state_q == WR) || (state_q == RMW_WR));
  assign bus.mem_write_data = (state_q == WR)     ? wdata_q :
                              (state_q == RMW_WR) ? merged  : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit_if if0 ();
  load_store_unit_if if1 ();

  load_store_unit #(.ALIGN_CHECK(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  load_store_unit #(.ALIGN_CHECK(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  int rd_cnt0 = 0;
  int wr_cnt0 = 0;

  always @(posedge clk) begin
    if (if0.mem_write) mem0[if0.mem_address[3:0]] <= if0.mem_write_data;
    if (if0.mem_read)  if0.mem_read_data <= mem0[if0.mem_address[3:0]];
    if (if0.mem_read)  rd_cnt0 <= rd_cnt0 + 1;
    if (if0.mem_write) wr_cnt0 <= wr_cnt0 + 1;
  end

  always @(posedge clk) begin
    if (if1.mem_write) mem1[if1.mem_address[3:0]] <= if1.mem_write_data;
    if (if1.mem_read)  if1.mem_read_data <= mem1[if1.mem_address[3:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request on if0 at a negedge, hold through the accepting edge.
  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if0.req_write = w; if0.req_size = sz; if0.req_signed = sg;
    if0.req_addr = a;  if0.req_wdata = d; if0.req_valid = 1'b1;
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
  endtask

  // Returns the negedge index (1 = first negedge after the accept edge) of the response.
  task automatic wait_resp(output int n, output logic [31:0] d, output logic m);
    n = 0; d = '0; m = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (if0.resp_valid) begin
        n = i; d = if0.resp_data; m = if0.misaligned;
        break;
      end
    end
  endtask

  task automatic test_reset();
    if0.req_valid = 0; if0.req_write = 0; if0.req_size = 0; if0.req_signed = 0;
    if0.req_addr = 0;  if0.req_wdata = 0;
    if1.req_valid = 0; if1.req_write = 0; if1.req_size = 0; if1.req_signed = 0;
    if1.req_addr = 0;  if1.req_wdata = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", if0.req_ready); end
    n_checks++; if (if0.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", if0.resp_valid); end
    n_checks++; if (if0.resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data got %h exp 0", if0.resp_data); end
    n_checks++; if (if0.misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got %b exp 0", if0.misaligned); end
    n_checks++; if ({if0.mem_read, if0.mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b exp 00", {if0.mem_read, if0.mem_write}); end
    n_checks++; if (if0.mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_mem_address got %h exp 0", if0.mem_address); end
    n_checks++; if (if0.mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0", if0.mem_write_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++; if (if0.mem_write !== 1'b1) begin n_fail++; $display("FAIL wst_mem_write got %b exp 1", if0.mem_write); end
    n_checks++; if (if0.mem_address !== 32'd4) begin n_fail++; $display("FAIL wst_mem_address got %h exp 4", if0.mem_address); end
    n_checks++; if (if0.mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wst_mem_wdata got %h exp deadbeef", if0.mem_write_data); end
    n_checks++; if (if0.req_ready !== 1'b0) begin n_fail++; $display("FAIL wst_ready_busy got %b exp 0", if0.req_ready); end
    @(negedge clk);
    n_checks++; if ({if0.resp_valid, if0.misaligned, if0.resp_data} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL wst_resp got v=%b m=%b d=%h exp v=1 m=0 d=0", if0.resp_valid, if0.misaligned, if0.resp_data); end
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    n_checks++; if ({if0.mem_read, if0.mem_write, if0.mem_address} !== {2'b10, 32'd4}) begin n_fail++; $display("FAIL wld_read got r=%b w=%b a=%h exp r=1 w=0 a=4", if0.mem_read, if0.mem_write, if0.mem_address); end
    @(negedge clk);
    n_checks++; if (if0.resp_valid !== 1'b0) begin n_fail++; $display("FAIL wld_early_resp got %b exp 0", if0.resp_valid); end
    @(negedge clk);
    n_checks++; if ({if0.resp_valid, if0.resp_data} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wld_resp got v=%b d=%h exp v=1 d=deadbeef", if0.resp_valid, if0.resp_data); end
    @(negedge clk);
    n_checks++; if ({if0.resp_valid, if0.resp_data} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wld_hold got v=%b d=%h exp v=0 d=deadbeef", if0.resp_valid, if0.resp_data); end
  endtask

  task automatic test_byte_store();
    int n; logic [31:0] d; logic m;
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    wait_resp(n, d, m);
    send(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFA5);
    @(negedge clk);
    n_checks++; if ({if0.mem_read, if0.mem_write} !== 2'b10) begin n_fail++; $display("FAIL bst_rd_phase got r=%b w=%b exp r=1 w=0", if0.mem_read, if0.mem_write); end
    @(negedge clk);
    n_checks++; if ({if0.mem_read, if0.mem_write, if0.mem_write_data} !== {2'b01, 32'h1122A544}) begin n_fail++; $display("FAIL bst_wr_phase got r=%b w=%b d=%h exp r=0 w=1 d=1122a544", if0.mem_read, if0.mem_write, if0.mem_write_data); end
    @(negedge clk);
    n_checks++; if (if0.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bst_resp got %b exp 1", if0.resp_valid); end
    n_checks++; if (mem0[4] !== 32'h1122A544) begin n_fail++; $display("FAIL bst_mem got %h exp 1122a544", mem0[4]); end
    send(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
    wait_resp(n, d, m);
    n_checks++; if (n !== 3 || mem0[4] !== 32'hBEEFA544) begin n_fail++; $display("FAIL hst_merge got n=%0d mem=%h exp n=3 mem=beefa544", n, mem0[4]); end
  endtask

  task automatic test_subword_loads();
    logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h11};
    logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0000007F};
    int n; logic [31:0] d; logic m;
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'h80017F00);
    wait_resp(n, d, m);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, sz[i], sg[i], ad[i], 32'h0);
      wait_resp(n, d, m);
      n_checks++; if (n !== 3 || d !== ex[i] || m !== 1'b0) begin n_fail++; $display("FAIL subload_%0d got n=%0d d=%h m=%b exp n=3 d=%h m=0", i, n, d, m, ex[i]); end
    end
  endtask

  task automatic test_misaligned();
    logic        wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h06, 32'h03, 32'h10};
    int n; logic [31:0] d; logic m; int rd0; int wr0;
    for (int i = 0; i < 3; i++) begin
      rd0 = rd_cnt0; wr0 = wr_cnt0;
      send(wr[i], sz[i], 1'b0, ad[i], 32'h12345678);
      wait_resp(n, d, m);
      n_checks++; if (n !== 1 || m !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL misal_%0d got n=%0d m=%b d=%h exp n=1 m=1 d=0", i, n, m, d); end
      @(negedge clk);
      n_checks++; if (rd_cnt0 !== rd0 || wr_cnt0 !== wr0 || if0.misaligned !== 1'b0) begin n_fail++; $display("FAIL misal_noaccess_%0d got rd=%0d wr=%0d m=%b exp rd=%0d wr=%0d m=0", i, rd_cnt0, wr_cnt0, if0.misaligned, rd0, wr0); end
    end
  endtask

  task automatic test_align_off();
    @(negedge clk);
    if1.req_write = 1'b0; if1.req_size = 2'b10; if1.req_addr = 32'h06; if1.req_valid = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({if1.mem_read, if1.mem_address} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL noalign_read got r=%b a=%h exp r=1 a=1", if1.mem_read, if1.mem_address); end
    repeat (2) @(negedge clk);
    n_checks++; if ({if1.resp_valid, if1.misaligned} !== 2'b10) begin n_fail++; $display("FAIL noalign_resp got v=%b m=%b exp v=1 m=0", if1.resp_valid, if1.misaligned); end
    @(negedge clk);
    if1.req_size = 2'b11; if1.req_addr = 32'h10; if1.req_valid = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({if1.resp_valid, if1.misaligned, if1.mem_read} !== 3'b110) begin n_fail++; $display("FAIL noalign_rsvd got v=%b m=%b r=%b exp v=1 m=1 r=0", if1.resp_valid, if1.misaligned, if1.mem_read); end
  endtask

  task automatic test_reset_mid_rmw();
    int n; logic [31:0] d; logic m; int seen;
    send(1'b1, 2'b10, 1'b0, 32'h18, 32'h55667788);
    wait_resp(n, d, m);
    send(1'b1, 2'b00, 1'b0, 32'h18, 32'h00000099);
    repeat (2) @(negedge clk);
    n_checks++; if (if0.mem_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_inwr got %b exp 1", if0.mem_write); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (if0.mem_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop got %b exp 0", if0.mem_write); end
    seen = 0;
    repeat (2) begin @(negedge clk); if (if0.resp_valid) seen++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (if0.resp_valid) seen++; end
    n_checks++; if (seen !== 0 || mem0[6] !== 32'h55667788) begin n_fail++; $display("FAIL rstmid_abandon got pulses=%0d mem=%h exp pulses=0 mem=55667788", seen, mem0[6]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    if0.req_write = 1'b0; if0.req_size = 2'b10; if0.req_signed = 1'b0;
    if0.req_addr = 32'h18; if0.req_wdata = 32'h0; if0.req_valid = 1'b1;
    n_checks++; if (if0.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle got %b exp 1", if0.req_ready); end
    @(posedge clk); #1;
    if0.req_write = 1'b1; if0.req_addr = 32'h1C; if0.req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    n_checks++; if ({if0.req_ready, if0.resp_valid, if0.mem_write} !== 3'b000) begin n_fail++; $display("FAIL b2b_n1 got rdy=%b v=%b w=%b exp 000", if0.req_ready, if0.resp_valid, if0.mem_write); end
    @(negedge clk);
    n_checks++; if ({if0.req_ready, if0.resp_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_n2 got rdy=%b v=%b exp 00", if0.req_ready, if0.resp_valid); end
    @(negedge clk);
    n_checks++; if ({if0.req_ready, if0.resp_valid, if0.resp_data} !== {2'b11, 32'h55667788}) begin n_fail++; $display("FAIL b2b_first got rdy=%b v=%b d=%h exp rdy=1 v=1 d=55667788", if0.req_ready, if0.resp_valid, if0.resp_data); end
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({if0.req_ready, if0.resp_valid, if0.mem_write, if0.mem_address} !== {3'b001, 32'd7}) begin n_fail++; $display("FAIL b2b_n4 got rdy=%b v=%b w=%b a=%h exp rdy=0 v=0 w=1 a=7", if0.req_ready, if0.resp_valid, if0.mem_write, if0.mem_address); end
    @(negedge clk);
    n_checks++; if ({if0.resp_valid, if0.resp_data} !== {1'b1, 32'h0} || mem0[7] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_second got v=%b d=%h mem=%h exp v=1 d=0 mem=cafef00d", if0.resp_valid, if0.resp_data, mem0[7]); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_subword_loads();
    test_misaligned();
    test_align_off();
    test_reset_mid_rmw();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ALIGN_CHECK, default 1, meaning 1 = misaligned requests are rejected with Misaligned; 0 = low address bits are ignored and the access is forced aligned.
REQ-002 Clk  in  1  single clock; all state changes on posedge.
REQ-003 Rst_n  in  1  asynchronous, active-low reset.
REQ-004 ReqValid  in  1  request present from execute stage.
REQ-005 ReqReady  out  1  unit can accept a request this cycle.
REQ-006 ReqWrite  in  1  1 = store, 0 = load.
REQ-007 ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 ReqSigned  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-009 ReqAddr  in  32  byte address.
REQ-010 ReqWData  in  32  store data, right-justified.
REQ-011 RespValid  out  1  one-cycle completion pulse.
REQ-012 RespData  out  32  load result; 0 for stores and errors.
REQ-013 Misaligned  out  1  qualifies RespValid; request rejected.
REQ-014 MemAddress  out  32  word index to data memory = {2'b00, addr_q[31:2]}.
REQ-015 MemWriteData, MemRead, MemWrite  out  32/1/1  data memory write data and strobes.
REQ-016 MemReadData  in  32  data memory read data, valid the cycle after the edge that sampled MemRead.

Function
REQ-017 FSM states SHALL be IDLE, RD, LD_DONE, WR, RMW_RD, RMW_WR; ReqReady = 1 only in IDLE.
REQ-018 Accept = ReqValid & ReqReady at posedge; accept latches addr_q, size_q, signed_q, write_q, wdata_q.
REQ-019 Misaligned check (ALIGN_CHECK=1): halfword with addr[0]=1, word with addr[1:0]!=0, or ReqSize=11; on accept the FSM stays in IDLE, registers RespValid=1, Misaligned=1, RespData=0, and issues no memory access.
REQ-020 With ALIGN_CHECK=0, ReqSize=11 is still rejected; other misalignments clear the offending low bits.
REQ-021 Transitions: IDLE->RD (load), IDLE->WR (word store), IDLE->RMW_RD (byte/half store); RD->LD_DONE; LD_DONE->IDLE; WR->IDLE; RMW_RD->RMW_WR; RMW_WR->IDLE.
REQ-022 MemRead = 1 in RD and RMW_RD only; MemWrite = 1 in WR and RMW_WR only; both combinational from state.
REQ-023 MemWriteData = wdata_q in WR; merged word in RMW_WR; 0 otherwise.
REQ-024 Lanes little-endian: byte lane = addr_q[1:0] at bits [8*lane+7:8*lane]; halfword lane = addr_q[1] at bits [16*h+15:16*h].
REQ-025 RMW merge: MemReadData with the selected lane replaced by low 8/16 bits of wdata_q; other lanes unchanged.
REQ-026 In LD_DONE the selected lane of MemReadData SHALL be extracted, sign/zero-extended per signed_q (word: unchanged), and registered into RespData with RespValid=1.
REQ-027 RespValid is set on the edge leaving LD_DONE, WR, RMW_WR, or on a misaligned accept, and is 0 in every other cycle; exactly one pulse per accepted request.
REQ-028 Latency (accept edge E0): word store writes at E1, RespValid high after E1; load reads at E1, RespValid high after E2; sub-word store reads at E1, writes at E2, RespValid high after E2.
REQ-029 Misaligned = 1 only together with RespValid; RespData holds its value between pulses.
REQ-030 ReqValid while ReqReady=0 is ignored; the request must be held by upstream until accepted.

Reset
REQ-031 Rst_n low SHALL immediately force IDLE, RespValid=0, RespData=0, Misaligned=0, all latched request registers 0; hence MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0.
REQ-032 Reset mid-operation abandons the request: no further memory write, no RespValid for it.

Verification
REQ-033 Word store 0xDEADBEEF @0x10, then word load @0x10 -> MemWrite with MemAddress=4 at E1; load RespData=0xDEADBEEF, RespValid 3 cycles after load accept edge's cycle sequence per REQ-028.
REQ-034 Memory word 4 = 0x11223344; byte store 0xA5 @0x11 -> MemRead then MemWrite with MemWriteData=0x1122A544.
REQ-035 Memory word 4 = 0x80017F00; byte load @0x13 signed -> 0xFFFFFF80; unsigned -> 0x00000080; half load @0x12 signed -> 0xFFFF8001.
REQ-036 Word load @0x06, ALIGN_CHECK=1 -> RespValid=1, Misaligned=1, RespData=0 next cycle, MemRead/MemWrite never asserted; ALIGN_CHECK=0 -> reads word index 1.
REQ-037 Rst_n low during RMW_WR -> MemWrite drops immediately, memory word unchanged, no RespValid.
REQ-038 ReqValid held high with two queued requests -> ReqReady low outside IDLE; second request accepted only in IDLE; two RespValid pulses in order.
